// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: in-order queue of predicted branches matched
// against ALU outcomes, driving predictor training, redirect and wrong-path flush.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             update,
  output logic             actual_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             underflow_err
);

  localparam int unsigned       PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [31:0]      pc_mem     [DEPTH];
  logic [31:0]      target_mem [DEPTH];
  logic [DEPTH-1:0] taken_mem;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic        full;
  logic        push;
  logic        resolve;
  logic        mis;
  logic        head_taken;
  logic [31:0] head_pc;
  logic [31:0] head_target;
  logic [31:0] next_pc;

  assign pred_ready = !full;

  always_comb begin
    full        = (count == FULL_CNT);
    push        = pred_valid && !full;
    resolve     = res_valid && (count != '0);
    head_pc     = pc_mem[rd_ptr];
    head_target = target_mem[rd_ptr];
    head_taken  = taken_mem[rd_ptr];
    // Target only matters when both prediction and outcome are taken.
    mis         = resolve && ((res_taken != head_taken) ||
                              (res_taken && (res_target != head_target)));
    next_pc     = res_taken ? res_target : head_pc + 32'd4;
  end

  // Occupancy and pointers; a mispredict flushes everything including a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mis) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (resolve) rd_ptr <= rd_ptr + 1'b1;
      if (push && !resolve)      count <= count + 1'b1;
      else if (!push && resolve) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !mis) begin
      pc_mem[wr_ptr]     <= pred_pc;
      target_mem[wr_ptr] <= pred_target;
      taken_mem[wr_ptr]  <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update         <= 1'b0;
      actual_taken   <= 1'b0;
      mispredict     <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      underflow_err  <= 1'b0;
    end else begin
      update     <= resolve;
      mispredict <= mis;
      if (resolve) begin
        actual_taken <= res_taken;
        redirect_pc  <= next_pc;
        if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 1'b1;
      end
      if (mis && (mispredict_cnt != CNT_MAX)) mispredict_cnt <= mispredict_cnt + 1'b1;
      if (res_valid && (count == '0)) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus reset/flush sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pred_valid = 1'b0;
  logic        pred_ready;
  logic [31:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        update;
  logic        actual_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
  logic        underflow_err;

  int total = 0;
  int bad   = 0;

  branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .update(update), .actual_taken(actual_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        pt;
    logic [31:0] ptg;
    logic        rv;
    logic        rt;
    logic [31:0] rtg;
    logic        e_rdy;
    logic        e_upd;
    logic        e_at;
    logic        e_mis;
    logic [31:0] e_red;
    logic [31:0] e_b;
    logic [31:0] e_m;
    logic        e_uf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int pv, logic [31:0] ppc, int pt, logic [31:0] ptg,
                              int rv, int rt, logic [31:0] rtg,
                              int rdy, int upd, int at, int mis, logic [31:0] red,
                              int b, int m, int uf);
    vec_t v;
    v.pv = (pv != 0); v.ppc = ppc; v.pt = (pt != 0); v.ptg = ptg;
    v.rv = (rv != 0); v.rt = (rt != 0); v.rtg = rtg;
    v.e_rdy = (rdy != 0); v.e_upd = (upd != 0); v.e_at = (at != 0);
    v.e_mis = (mis != 0); v.e_red = red; v.e_b = 32'(b); v.e_m = 32'(m);
    v.e_uf = (uf != 0);
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, logic rdy, logic upd, logic at, logic mis,
                          logic [31:0] red, logic [31:0] b, logic [31:0] m, logic uf);
    chk({tag, ".pred_ready"},     32'(pred_ready),    32'(rdy));
    chk({tag, ".update"},         32'(update),        32'(upd));
    chk({tag, ".actual_taken"},   32'(actual_taken),  32'(at));
    chk({tag, ".mispredict"},     32'(mispredict),    32'(mis));
    chk({tag, ".redirect_pc"},    redirect_pc,        red);
    chk({tag, ".branch_cnt"},     branch_cnt,         b);
    chk({tag, ".mispredict_cnt"}, mispredict_cnt,     m);
    chk({tag, ".underflow_err"},  32'(underflow_err), 32'(uf));
  endtask

  task automatic step(logic pv, logic [31:0] ppc, logic pt, logic [31:0] ptg,
                      logic rv, logic rt, logic [31:0] rtg);
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    @(posedge clk);
    #1;
    pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic do_reset(string tag);
    reset_n = 1'b0;
    pred_valid = 1'b0; res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    // pv ppc pt ptg | rv rt rtg | rdy upd at mis redirect bcnt mcnt uf
    vq.push_back(mk(1,'h100,1,'h200,      0,0,0,        1,0,0,0,'h200*0,0,0,0));
    vq.push_back(mk(0,0,0,0,              1,1,'h200,    1,1,1,0,'h200,1,0,0));
    vq.push_back(mk(1,'h100,0,'hdead,     0,0,0,        1,0,1,0,'h200,1,0,0));
    vq.push_back(mk(0,0,0,0,              1,1,'h180,    1,1,1,1,'h180,2,1,0));
    vq.push_back(mk(1,'h40,1,'h80,        0,0,0,        1,0,1,0,'h180,2,1,0));
    vq.push_back(mk(0,0,0,0,              1,0,'h999,    1,1,0,1,'h44,3,2,0));
    vq.push_back(mk(1,'h300,1,'h200,      0,0,0,        1,0,0,0,'h44,3,2,0));
    vq.push_back(mk(0,0,0,0,              1,1,'h204,    1,1,1,1,'h204,4,3,0));
    vq.push_back(mk(1,'h500,0,'h777,      0,0,0,        1,0,1,0,'h204,4,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,'h123,    1,1,0,0,'h504,5,3,0));
    vq.push_back(mk(1,'hFFFFFFFC,0,0,     0,0,0,        1,0,0,0,'h504,5,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,0,        1,1,0,0,'h0,6,3,0));
    vq.push_back(mk(1,'h1000,1,'h1100,    0,0,0,        1,0,0,0,'h0,6,3,0));
    vq.push_back(mk(1,'h1004,0,0,         0,0,0,        1,0,0,0,'h0,6,3,0));
    vq.push_back(mk(1,'h1008,1,'h1200,    0,0,0,        1,0,0,0,'h0,6,3,0));
    vq.push_back(mk(1,'h100C,0,0,         0,0,0,        0,0,0,0,'h0,6,3,0));
    vq.push_back(mk(1,'h2000,1,'h3000,    0,0,0,        0,0,0,0,'h0,6,3,0));
    vq.push_back(mk(0,0,0,0,              1,1,'h1100,   1,1,1,0,'h1100,7,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,'h5555,   1,1,0,0,'h1008,8,3,0));
    vq.push_back(mk(0,0,0,0,              1,1,'h1200,   1,1,1,0,'h1200,9,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,0,        1,1,0,0,'h1010,10,3,0));
    vq.push_back(mk(1,'h600,1,'h700,      0,0,0,        1,0,0,0,'h1010,10,3,0));
    vq.push_back(mk(1,'h610,0,0,          1,1,'h700,    1,1,1,0,'h700,11,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,0,        1,1,0,0,'h614,12,3,0));
    vq.push_back(mk(1,'h800,0,0,          0,0,0,        1,0,0,0,'h614,12,3,0));
    vq.push_back(mk(1,'h810,0,0,          0,0,0,        1,0,0,0,'h614,12,3,0));
    vq.push_back(mk(1,'h820,0,0,          0,0,0,        1,0,0,0,'h614,12,3,0));
    vq.push_back(mk(1,'h830,0,0,          0,0,0,        0,0,0,0,'h614,12,3,0));
    vq.push_back(mk(1,'h900,0,0,          1,0,0,        1,1,0,0,'h804,13,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,0,        1,1,0,0,'h814,14,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,0,        1,1,0,0,'h824,15,3,0));
    vq.push_back(mk(0,0,0,0,              1,0,0,        1,1,0,0,'h834,16,3,0));
    // Queue is empty here unless the push offered while full was wrongly accepted.
    vq.push_back(mk(0,0,0,0,              1,1,'h999,    1,0,0,0,'h834,16,3,1));

    do_reset("reset0");
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].pv, vq[i].ppc, vq[i].pt, vq[i].ptg, vq[i].rv, vq[i].rt, vq[i].rtg);
      chk_outs($sformatf("vec%0d", i), vq[i].e_rdy, vq[i].e_upd, vq[i].e_at, vq[i].e_mis,
               vq[i].e_red, vq[i].e_b, vq[i].e_m, vq[i].e_uf);
    end

    // Mispredict flush with a same-cycle push that must be dropped.
    do_reset("reset1");
    step(1'b1, 32'hA00, 1'b1, 32'hB00, 1'b0, 1'b0, '0);
    step(1'b1, 32'hA10, 1'b0, '0,      1'b0, 1'b0, '0);
    step(1'b1, 32'hA20, 1'b0, '0,      1'b0, 1'b0, '0);
    step(1'b1, 32'hC00, 1'b0, '0,      1'b1, 1'b0, '0);
    chk_outs("flush", 1'b1, 1'b1, 1'b0, 1'b1, 32'hA04, 32'd1, 32'd1, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'hB00);
    chk_outs("flush_uf", 1'b1, 1'b0, 1'b0, 1'b0, 32'hA04, 32'd1, 32'd1, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    chk_outs("uf_sticky", 1'b1, 1'b0, 1'b0, 1'b0, 32'hA04, 32'd1, 32'd1, 1'b1);

    // Asynchronous reset with two entries queued and an update pending.
    do_reset("reset2");
    step(1'b1, 32'hD00, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hD10, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 32'hD20, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk_outs("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 32'hD04, 32'd1, 32'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_outs("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
    chk_outs("post_rst_empty", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Asynchronous reset while a mispredict pulse is pending.
    do_reset("reset3");
    step(1'b1, 32'hE00, 1'b1, 32'hE80, 1'b0, 1'b0, '0);
    step(1'b1, 32'hE10, 1'b0, '0,      1'b0, 1'b0, '0);
    step(1'b1, 32'hE20, 1'b0, '0,      1'b1, 1'b0, '0);
    chk_outs("pre_rst_mis", 1'b1, 1'b1, 1'b0, 1'b1, 32'hE04, 32'd1, 32'd1, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_outs("async_rst_mis", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
